// File: rtl/prim_pad_input_filter.sv
// Per-pad input conditioning: synchronizer, debounce filter, edge pulses and a
// sticky wakeup detector, all in the clk_i domain.
module prim_pad_input_filter #(
  parameter int unsigned NumPads    = 4,
  parameter int unsigned CntWidth   = 16,
  parameter int unsigned SyncStages = 2,
  parameter logic        ResetVal   = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumPads-1:0]    in_i,
  input  logic [NumPads-1:0]    filter_en_i,
  input  logic [CntWidth-1:0]   debounce_cnt_i,
  input  logic [NumPads-1:0]    wkup_en_i,
  input  logic [3*NumPads-1:0]  wkup_mode_i,
  input  logic [NumPads-1:0]    wkup_clr_i,
  output logic [NumPads-1:0]    filtered_o,
  output logic [NumPads-1:0]    rise_o,
  output logic [NumPads-1:0]    fall_o,
  output logic [NumPads-1:0]    wkup_o,
  output logic                  wkup_any_o
);

  if (SyncStages < 2) begin : g_bad_sync_stages
    $error("prim_pad_input_filter: SyncStages must be >= 2");
  end

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

  logic [NumPads-1:0]  sync_q [SyncStages];
  logic [NumPads-1:0]  s;
  logic [CntWidth-1:0] thr_base;
  logic [NumPads-1:0]  prev_q;
  logic [NumPads-1:0]  hit;
  logic [NumPads-1:0]  wkup_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < SyncStages; k++) sync_q[k] <= {NumPads{ResetVal}};
    end else begin
      sync_q[0] <= in_i;
      for (int unsigned k = 1; k < SyncStages; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s        = sync_q[SyncStages-1];
  assign thr_base = (debounce_cnt_i == '0) ? CntWidth'(1) : debounce_cnt_i;

  for (genvar i = 0; i < NumPads; i++) begin : g_pad
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [CntWidth-1:0] thr;
    logic                filt_q, filt_d;

    assign thr = filter_en_i[i] ? thr_base : CntWidth'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        filt_q  <= ResetVal;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        filt_q  <= filt_d;
      end
    end

    // Using >= rather than == lets a threshold lowered mid-count release at once.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      filt_d  = filt_q;
      unique case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (s[i] != filt_q) begin
            if (thr == CntWidth'(1)) begin
              filt_d = s[i];
            end else begin
              cnt_d   = CntWidth'(1);
              state_d = ST_COUNTING;
            end
          end
        end
        ST_COUNTING: begin
          if (s[i] == filt_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q >= thr - CntWidth'(1)) begin
            filt_d  = s[i];
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q + CntWidth'(1);
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
    end

    assign filtered_o[i] = filt_q;

    always_comb begin
      hit[i] = 1'b0;
      case (wkup_mode_i[3*i +: 3])
        3'd0:    hit[i] = rise_o[i];
        3'd1:    hit[i] = fall_o[i];
        3'd2:    hit[i] = rise_o[i] | fall_o[i];
        3'd3:    hit[i] = filt_q;
        3'd4:    hit[i] = ~filt_q;
        default: hit[i] = 1'b0;
      endcase
      hit[i] = hit[i] & wkup_en_i[i];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= {NumPads{ResetVal}};
    else       prev_q <= filtered_o;
  end

  assign rise_o = filtered_o & ~prev_q;
  assign fall_o = ~filtered_o & prev_q;

  // A hit in the same cycle as a clear keeps the flag set.
  assign wkup_d = hit | (wkup_o & ~wkup_clr_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wkup_o     <= '0;
      wkup_any_o <= 1'b0;
    end else begin
      wkup_o     <= wkup_d;
      wkup_any_o <= |wkup_d;
    end
  end

endmodule
